// File: rtl/player2_ctl_pkg.sv
// rtl/player2_ctl_pkg.sv - pose/vertical enums and screen geometry for the player-2 controller
package player2_ctl_pkg;

    localparam int SCREEN_W = 800;
    localparam int SPRITE_W = 40;

    localparam int X_INIT_DEF  = 400;
    localparam int X_MIN_DEF   = 0;
    localparam int X_MAX_DEF   = SCREEN_W - SPRITE_W;
    localparam int STEP_DEF    = 4;
    localparam int JUMP_V0_DEF = 12;
    localparam int GRAVITY_DEF = 1;

    typedef enum logic [1:0] {
        IDLE2  = 2'd0,
        RIGHT2 = 2'd1,
        LEFT2  = 2'd2
    } state2_t;

    typedef enum logic {
        GROUND2 = 1'b0,
        AIR2    = 1'b1
    } vstate2_t;

endpackage

// File: rtl/player2_ctl_if.sv
// rtl/player2_ctl_if.sv - frame/button inputs and sprite position outputs of the player-2 controller
interface player2_ctl_if;
    import player2_ctl_pkg::*;

    logic        vsync;
    logic        btn_left;
    logic        btn_right;
    logic        btn_jump;
    logic [11:0] xpos_player2;
    logic [11:0] ypos_player2;
    state2_t     state;
    logic        airborne;

    modport master (
        output vsync, btn_left, btn_right, btn_jump,
        input  xpos_player2, ypos_player2, state, airborne
    );

    modport slave (
        input  vsync, btn_left, btn_right, btn_jump,
        output xpos_player2, ypos_player2, state, airborne
    );

endinterface

// File: rtl/player2_ctl_frame_tick.sv
// rtl/player2_ctl_frame_tick.sv - registered one-cycle pulse on each vsync rising edge
module frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic tick
);

    logic vsync_q;

    // History resets high so a vsync already high at release is not a frame start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vsync_q <= 1'b1;
            tick    <= 1'b0;
        end else begin
            vsync_q <= vsync;
            tick    <= vsync & ~vsync_q;
        end
    end

endmodule

// File: rtl/player2_ctl.sv
// rtl/player2_ctl.sv - per-frame horizontal/jump motion of player 2; jump logic under PLAYER2_JUMP_EN
module player2_ctl
    import player2_ctl_pkg::*;
#(
    parameter int X_INIT  = X_INIT_DEF,
    parameter int X_MIN   = X_MIN_DEF,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int STEP    = STEP_DEF,
    parameter int JUMP_V0 = JUMP_V0_DEF,
    parameter int GRAVITY = GRAVITY_DEF
) (
    input logic          clk,
    input logic          rst,
    player2_ctl_if.slave bus
);

    localparam logic [12:0] STEP13  = 13'(STEP);
    localparam logic [12:0] X_MIN13 = 13'(X_MIN);
    localparam logic [12:0] X_MAX13 = 13'(X_MAX);

    logic        tick;
    state2_t     state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [12:0] x13;

    frame_tick u_frame_tick (
        .clk   (clk),
        .rst   (rst),
        .vsync (bus.vsync),
        .tick  (tick)
    );

    assign x13 = {1'b0, x_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE2;
            x_q     <= 12'(X_INIT);
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
        end
    end

    // Pose follows the buttons even when the position is pinned at a wall.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        if (tick) begin
            if (bus.btn_left && !bus.btn_right) begin
                state_d = LEFT2;
                x_d     = (x13 < X_MIN13 + STEP13) ? X_MIN13[11:0] : 12'(x13 - STEP13);
            end else if (bus.btn_right && !bus.btn_left) begin
                state_d = RIGHT2;
                x_d     = (x13 + STEP13 > X_MAX13) ? X_MAX13[11:0] : 12'(x13 + STEP13);
            end else begin
                state_d = IDLE2;
            end
        end
    end

    assign bus.xpos_player2 = x_q;
    assign bus.state        = state_q;

`ifdef PLAYER2_JUMP_EN
    vstate2_t           vstate_q, vstate_d;
    logic [11:0]        y_q, y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic signed [13:0] y_sum;

    assign y_sum = $signed({2'b00, y_q}) + $signed({{6{vel_q[7]}}, vel_q});

    always_ff @(posedge clk) begin
        if (!rst) begin
            vstate_q <= GROUND2;
            y_q      <= 12'd0;
            vel_q    <= 8'sd0;
        end else begin
            vstate_q <= vstate_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
        end
    end

    // Takeoff leaves y untouched; the first rise shows on the following tick.
    always_comb begin
        vstate_d = vstate_q;
        y_d      = y_q;
        vel_d    = vel_q;
        if (tick) begin
            case (vstate_q)
                GROUND2: begin
                    if (bus.btn_jump) begin
                        vstate_d = AIR2;
                        vel_d    = 8'(JUMP_V0);
                    end
                end
                AIR2: begin
                    if (y_sum <= 14'sd0) begin
                        vstate_d = GROUND2;
                        y_d      = 12'd0;
                        vel_d    = 8'sd0;
                    end else begin
                        y_d   = y_sum[11:0];
                        vel_d = vel_q - 8'(GRAVITY);
                    end
                end
                default: vstate_d = GROUND2;
            endcase
        end
    end

    assign bus.ypos_player2 = y_q;
    assign bus.airborne     = (vstate_q == AIR2);
`else
    logic unused_jump;
    assign unused_jump      = bus.btn_jump;
    assign bus.ypos_player2 = 12'd0;
    assign bus.airborne     = 1'b0;
`endif

endmodule

// File: tb/tb_player2_ctl.sv
// tb/tb_player2_ctl.sv - randomized frame stimulus against a trajectory-level player-2 model
module tb_player2_ctl;
    import player2_ctl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    int   mx, my, ms, mk;
    bit   mair;

    always #5 clk = ~clk;

    player2_ctl_if bus ();

    player2_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = 400; my = 0; ms = int'(IDLE2); mair = 0; mk = 0;
    endtask

    // Height after k ticks of flight: v0*k - g*k*(k-1)/2, landing once it reaches 0.
    task automatic model_tick(input bit l, input bit r, input bit j);
        if (l && !r) begin
            ms = int'(LEFT2);
            mx = (mx - 4 < 0) ? 0 : mx - 4;
        end else if (r && !l) begin
            ms = int'(RIGHT2);
            mx = (mx + 4 > 760) ? 760 : mx + 4;
        end else begin
            ms = int'(IDLE2);
        end
`ifdef PLAYER2_JUMP_EN
        if (mair) begin
            mk++;
            my = 12 * mk - (mk * (mk - 1)) / 2;
            if (my <= 0) begin
                my = 0; mair = 0;
            end
        end else if (j) begin
            mair = 1; mk = 0;
        end
`endif
    endtask

    task automatic check_all(input string tag);
        check({tag, "_x"}, int'(bus.xpos_player2), mx);
        check({tag, "_y"}, int'(bus.ypos_player2), my);
        check({tag, "_st"}, int'(bus.state), ms);
        check({tag, "_air"}, int'(bus.airborne), int'(mair));
    endtask

    task automatic do_frame(input bit l, input bit r, input bit j, input bit lat, input string tag);
        @(negedge clk);
        bus.btn_left = l; bus.btn_right = r; bus.btn_jump = j;
        bus.vsync = 1'b1;
        @(posedge clk); #1;
        if (lat) check({tag, "_lat_hold"}, int'(bus.xpos_player2), mx);
        @(posedge clk); #1;
        model_tick(l, r, j);
        if (lat) check({tag, "_lat_upd"}, int'(bus.xpos_player2), mx);
        @(negedge clk);
        bus.vsync = 1'b0;
        repeat (2) @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int air_cnt, y_peak;
        bus.vsync = 1'b1; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_jump = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");

        // vsync high through reset release must not produce a tick
        rst = 1'b1; bus.btn_right = 1'b1;
        repeat (5) @(negedge clk);
        check("no_false_tick_x", int'(bus.xpos_player2), 400);
        check("no_false_tick_st", int'(bus.state), int'(IDLE2));
        bus.vsync = 1'b0; bus.btn_right = 1'b0;
        repeat (2) @(negedge clk);

        for (int f = 0; f < 5; f++) do_frame(0, 1, 0, f == 0, "right5");
        check("right5_x420", int'(bus.xpos_player2), 420);
        do_frame(1, 1, 0, 0, "both");
        check("both_idle", int'(bus.state), int'(IDLE2));

        for (int f = 0; f < 90; f++) do_frame(0, 1, 0, 0, "wall_r");
        check("wall_r_760", int'(bus.xpos_player2), 760);

        for (int f = 0; f < 193; f++) do_frame(1, 0, 0, 0, "wall_l");
        check("wall_l_0", int'(bus.xpos_player2), 0);
        check("wall_l_st", int'(bus.state), int'(LEFT2));

        air_cnt = 0; y_peak = 0;
        for (int f = 0; f < 30; f++) begin
            do_frame(0, 1, (f == 0) || (f == 5), 0, "jump");
            if (bus.airborne) air_cnt++;
            if (int'(bus.ypos_player2) > y_peak) y_peak = int'(bus.ypos_player2);
        end
`ifdef PLAYER2_JUMP_EN
        check("jump_air_ticks", air_cnt, 25);
        check("jump_peak", y_peak, 78);
`else
        check("jump_air_ticks", air_cnt, 0);
        check("jump_peak", y_peak, 0);
`endif

        for (int f = 0; f < 10; f++) do_frame(1, 0, f == 0, 0, "prerst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_all("midjump_rst");

        for (int f = 0; f < 80; f++) begin
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0, 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
